// File: rtl/kmeans_pkg.sv
// Shared constants and types for the colour-clustering datapath.
// Pixel layout is R=[23:16], G=[15:8], B=[7:0].
package kmeans_pkg;

    localparam int RGB_W = 24;
    localparam int D_W   = 10;
    localparam int K     = 8;
    localparam int LBL_W = 3;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        READ
    } state_e;

endpackage

// File: rtl/argmin8.sv
// Combinational nearest-centroid picker over eight distances.
// Strict less-than at every node keeps the lower index on ties.
module argmin8
    import kmeans_pkg::*;
(
    input  logic [D_W-1:0]   d_0,
    input  logic [D_W-1:0]   d_1,
    input  logic [D_W-1:0]   d_2,
    input  logic [D_W-1:0]   d_3,
    input  logic [D_W-1:0]   d_4,
    input  logic [D_W-1:0]   d_5,
    input  logic [D_W-1:0]   d_6,
    input  logic [D_W-1:0]   d_7,
    output logic [LBL_W-1:0] idx
);

    logic [D_W-1:0]   v0, v1, v2, v3, w0, w1;
    logic [LBL_W-1:0] i0, i1, i2, i3, j0, j1;

    always_comb begin
        i0 = (d_1 < d_0) ? 3'd1 : 3'd0;
        v0 = (d_1 < d_0) ? d_1 : d_0;
        i1 = (d_3 < d_2) ? 3'd3 : 3'd2;
        v1 = (d_3 < d_2) ? d_3 : d_2;
        i2 = (d_5 < d_4) ? 3'd5 : 3'd4;
        v2 = (d_5 < d_4) ? d_5 : d_4;
        i3 = (d_7 < d_6) ? 3'd7 : 3'd6;
        v3 = (d_7 < d_6) ? d_7 : d_6;

        j0 = (v1 < v0) ? i1 : i0;
        w0 = (v1 < v0) ? v1 : v0;
        j1 = (v3 < v2) ? i3 : i2;
        w1 = (v3 < v2) ? v3 : v2;

        idx = (w1 < w0) ? j1 : j0;
    end

endmodule

// File: rtl/cluster_accum.sv
// Label select, per-cluster RGB/count banks and frame-end readout.
// Stage 1 registers the argmin; stage 2 folds the pixel into its bank.
module cluster_accum
    import kmeans_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int SUM_W = CNT_W + 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 pix_valid,
    input  logic [RGB_W-1:0]     pix_in,
    input  logic [D_W-1:0]       d_0,
    input  logic [D_W-1:0]       d_1,
    input  logic [D_W-1:0]       d_2,
    input  logic [D_W-1:0]       d_3,
    input  logic [D_W-1:0]       d_4,
    input  logic [D_W-1:0]       d_5,
    input  logic [D_W-1:0]       d_6,
    input  logic [D_W-1:0]       d_7,
    input  logic                 frame_end,
    output logic                 label_valid,
    output logic [LBL_W-1:0]     label,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [LBL_W-1:0]     rd_idx,
    output logic [SUM_W-1:0]     rd_sum_r,
    output logic [SUM_W-1:0]     rd_sum_g,
    output logic [SUM_W-1:0]     rd_sum_b,
    output logic [CNT_W-1:0]     rd_count,
    output logic                 frame_done,
    output logic                 err_drop
);

    state_e state_q, state_d;

    logic             lv_q, lv_d;
    logic             acc_q, acc_d;
    logic [LBL_W-1:0] lbl_q, lbl_d, amin;
    logic [RGB_W-1:0] pix_q, pix_d;
    logic [LBL_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [SUM_W-1:0] sr_q [K];
    logic [SUM_W-1:0] sr_d [K];
    logic [SUM_W-1:0] sg_q [K];
    logic [SUM_W-1:0] sg_d [K];
    logic [SUM_W-1:0] sb_q [K];
    logic [SUM_W-1:0] sb_d [K];
    logic [CNT_W-1:0] cnt_q [K];
    logic [CNT_W-1:0] cnt_d [K];

    logic hs, last_hs;

    argmin8 u_argmin (
        .d_0 (d_0),
        .d_1 (d_1),
        .d_2 (d_2),
        .d_3 (d_3),
        .d_4 (d_4),
        .d_5 (d_5),
        .d_6 (d_6),
        .d_7 (d_7),
        .idx (amin)
    );

    assign hs      = (state_q == READ) && rd_ready;
    assign last_hs = hs && (idx_q == LBL_W'(K - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            unique case (state_q)
                ACCUM:   if (frame_end) state_d = DRAIN;
                DRAIN:   state_d = READ;
                READ:    if (last_hs) state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    always_comb begin
        rd_valid = (state_q == READ);
    end

    // acc_q remembers whether the registered pixel was taken in ACCUM,
    // so a pixel dropped on the final handshake never lands in a new frame.
    always_comb begin
        lv_d   = pix_valid;
        lbl_d  = amin;
        pix_d  = pix_in;
        acc_d  = pix_valid && (state_q == ACCUM);
        err_d  = err_q || (pix_valid && (state_q != ACCUM));
        done_d = last_hs;
        idx_d  = hs ? idx_q + LBL_W'(1) : idx_q;

        for (int k = 0; k < K; k++) begin
            sr_d[k]  = sr_q[k];
            sg_d[k]  = sg_q[k];
            sb_d[k]  = sb_q[k];
            cnt_d[k] = cnt_q[k];
        end

        if (acc_q && (cnt_q[lbl_q] != {CNT_W{1'b1}})) begin
            sr_d[lbl_q]  = sr_q[lbl_q] + SUM_W'(pix_q[23:16]);
            sg_d[lbl_q]  = sg_q[lbl_q] + SUM_W'(pix_q[15:8]);
            sb_d[lbl_q]  = sb_q[lbl_q] + SUM_W'(pix_q[7:0]);
            cnt_d[lbl_q] = cnt_q[lbl_q] + CNT_W'(1);
        end

        if (last_hs || clear) begin
            for (int k = 0; k < K; k++) begin
                sr_d[k]  = '0;
                sg_d[k]  = '0;
                sb_d[k]  = '0;
                cnt_d[k] = '0;
            end
        end

        if (clear) begin
            lv_d   = 1'b0;
            lbl_d  = '0;
            pix_d  = '0;
            acc_d  = 1'b0;
            err_d  = 1'b0;
            done_d = 1'b0;
            idx_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lv_q   <= 1'b0;
            lbl_q  <= '0;
            pix_q  <= '0;
            acc_q  <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            idx_q  <= '0;
            for (int k = 0; k < K; k++) begin
                sr_q[k]  <= '0;
                sg_q[k]  <= '0;
                sb_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            lv_q   <= lv_d;
            lbl_q  <= lbl_d;
            pix_q  <= pix_d;
            acc_q  <= acc_d;
            err_q  <= err_d;
            done_q <= done_d;
            idx_q  <= idx_d;
            for (int k = 0; k < K; k++) begin
                sr_q[k]  <= sr_d[k];
                sg_q[k]  <= sg_d[k];
                sb_q[k]  <= sb_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign label_valid = lv_q;
    assign label       = lbl_q;
    assign rd_idx      = idx_q;
    assign rd_sum_r    = sr_q[idx_q];
    assign rd_sum_g    = sg_q[idx_q];
    assign rd_sum_b    = sb_q[idx_q];
    assign rd_count    = cnt_q[idx_q];
    assign frame_done  = done_q;
    assign err_drop    = err_q;

endmodule

// File: tb/tb_cluster_accum.sv
// Bench for cluster_accum: behavioural frame model plus directed cases.
// A narrow count width makes count saturation reachable in a short run.
module tb_cluster_accum;

    localparam int CNT_W = 4;
    localparam int SUM_W = CNT_W + 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             pix_valid = 1'b0;
    logic [23:0]      pix_in = '0;
    logic [9:0]       d [8];
    logic             frame_end = 1'b0;
    logic             rd_ready = 1'b0;
    logic             label_valid;
    logic [2:0]       label;
    logic             rd_valid;
    logic [2:0]       rd_idx;
    logic [SUM_W-1:0] rd_sum_r, rd_sum_g, rd_sum_b;
    logic [CNT_W-1:0] rd_count;
    logic             frame_done;
    logic             err_drop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cluster_accum #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .pix_valid   (pix_valid),
        .pix_in      (pix_in),
        .d_0         (d[0]),
        .d_1         (d[1]),
        .d_2         (d[2]),
        .d_3         (d[3]),
        .d_4         (d[4]),
        .d_5         (d[5]),
        .d_6         (d[6]),
        .d_7         (d[7]),
        .frame_end   (frame_end),
        .label_valid (label_valid),
        .label       (label),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_idx      (rd_idx),
        .rd_sum_r    (rd_sum_r),
        .rd_sum_g    (rd_sum_g),
        .rd_sum_b    (rd_sum_b),
        .rd_count    (rd_count),
        .frame_done  (frame_done),
        .err_drop    (err_drop)
    );

    task automatic check(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 collect, 1 settle, 2 readout.
    int m_sr [8], m_sg [8], m_sb [8], m_cnt [8];
    int phase, ridx, m_lbl, pend_lbl;
    bit m_lv, m_done, m_err, pend, acc;
    logic [23:0] pend_pix;

    function automatic int nearest();
        int best = 0;
        for (int i = 1; i < 8; i++) if (d[i] < d[best]) best = i;
        return best;
    endfunction

    function automatic void zero_banks();
        for (int i = 0; i < 8; i++) begin
            m_sr[i] = 0; m_sg[i] = 0; m_sb[i] = 0; m_cnt[i] = 0;
        end
    endfunction

    function automatic void m_reset();
        zero_banks();
        phase = 0; ridx = 0; m_lbl = 0;
        m_lv = 0; m_done = 0; m_err = 0; pend = 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            m_reset();
        end else begin
            if (pend && m_cnt[pend_lbl] < CMAX) begin
                m_cnt[pend_lbl] += 1;
                m_sr[pend_lbl] += int'(pend_pix[23:16]);
                m_sg[pend_lbl] += int'(pend_pix[15:8]);
                m_sb[pend_lbl] += int'(pend_pix[7:0]);
            end
            acc = pix_valid && phase == 0;
            if (pix_valid && phase != 0) m_err = 1;
            m_lv = pix_valid;
            m_lbl = nearest();
            m_done = 0;
            if (phase == 2) begin
                if (rd_ready) begin
                    if (ridx == 7) begin
                        zero_banks(); ridx = 0; phase = 0; m_done = 1;
                    end else begin
                        ridx++;
                    end
                end
            end else if (phase == 1) begin
                phase = 2; ridx = 0;
            end else if (frame_end) begin
                phase = 1;
            end
            pend = acc;
            pend_pix = pix_in;
            pend_lbl = m_lbl;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_label_valid", int'(label_valid), int'(m_lv));
            if (m_lv) check("m_label", int'(label), m_lbl);
            check("m_rd_valid", int'(rd_valid), int'(phase == 2));
            check("m_rd_idx", int'(rd_idx), ridx);
            if (phase == 2) begin
                check("m_sum_r", int'(rd_sum_r), m_sr[ridx]);
                check("m_sum_g", int'(rd_sum_g), m_sg[ridx]);
                check("m_sum_b", int'(rd_sum_b), m_sb[ridx]);
                check("m_count", int'(rd_count), m_cnt[ridx]);
            end
            check("m_frame_done", int'(frame_done), int'(m_done));
            check("m_err_drop", int'(err_drop), int'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [23:0] p, input int lbl, input bit fe);
        pix_valid = 1'b1;
        pix_in = p;
        for (int i = 0; i < 8; i++) d[i] = (i == lbl) ? 10'd1 : 10'd500;
        frame_end = fe;
        tick();
        pix_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic read_frame(input int er [8], input int eg [8],
                              input int eb [8], input int ec [8],
                              input int stall, input int nst, input int drop);
        int w = 0;
        rd_ready = 1'b1;
        while (!rd_valid && w < 10) begin
            tick();
            w++;
        end
        check("rd_valid_wait", int'(rd_valid), 1);
        for (int i = 0; i < 8; i++) begin
            if (i == stall) begin
                rd_ready = 1'b0;
                repeat (nst) begin
                    tick();
                    check("stall_idx", int'(rd_idx), i);
                    check("stall_sum_r", int'(rd_sum_r), er[i]);
                    check("stall_count", int'(rd_count), ec[i]);
                end
                rd_ready = 1'b1;
            end
            check("rd_idx", int'(rd_idx), i);
            check("rd_sum_r", int'(rd_sum_r), er[i]);
            check("rd_sum_g", int'(rd_sum_g), eg[i]);
            check("rd_sum_b", int'(rd_sum_b), eb[i]);
            check("rd_count", int'(rd_count), ec[i]);
            if (i == drop) pix_valid = 1'b1;
            tick();
            pix_valid = 1'b0;
        end
        check("frame_done", int'(frame_done), 1);
        check("rd_valid_after", int'(rd_valid), 0);
        rd_ready = 1'b0;
    endtask

    int er [8], eg [8], eb [8], ec [8], z [8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            d[i] = '0;
            z[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_label_valid", int'(label_valid), 0);
        check("rst_label", int'(label), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_idx", int'(rd_idx), 0);
        check("rst_rd_sum_r", int'(rd_sum_r), 0);
        check("rst_rd_count", int'(rd_count), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_err_drop", int'(err_drop), 0);
        rst = 1'b0;
        tick();

        // nearest centroid and tie breaking
        pix_valid = 1'b1;
        d = '{10'd50, 10'd40, 10'd30, 10'd20, 10'd10, 10'd60, 10'd70, 10'd80};
        tick();
        check("near_valid", int'(label_valid), 1);
        check("near_label", int'(label), 4);
        for (int i = 0; i < 8; i++) d[i] = 10'd100;
        tick();
        check("tie_all", int'(label), 0);
        for (int i = 0; i < 8; i++) d[i] = (i == 3 || i == 5) ? 10'd5 : 10'd9;
        tick();
        check("tie_3_5", int'(label), 3);
        pix_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_lv", int'(label_valid), 0);

        // directed frame
        pix(24'h0A141E, 2, 0);
        pix(24'h143C28, 2, 0);
        pix(24'hFF0000, 7, 1);
        er = '{0, 0, 30, 0, 0, 0, 0, 255};
        eg = '{0, 0, 80, 0, 0, 0, 0, 0};
        eb = '{0, 0, 70, 0, 0, 0, 0, 0};
        ec = '{0, 0, 2, 0, 0, 0, 0, 1};
        read_frame(er, eg, eb, ec, -1, 0, -1);

        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        read_frame(z, z, z, z, -1, 0, -1);

        // backpressure at idx 3 and a dropped pixel during readout
        pix(24'h102030, 3, 0);
        pix(24'h050505, 5, 1);
        er = '{0, 0, 0, 16, 0, 5, 0, 0};
        eg = '{0, 0, 0, 32, 0, 5, 0, 0};
        eb = '{0, 0, 0, 48, 0, 5, 0, 0};
        ec = '{0, 0, 0, 1, 0, 1, 0, 0};
        read_frame(er, eg, eb, ec, 3, 5, 4);
        check("err_drop_set", int'(err_drop), 1);

        pix(24'h0F0F0F, 1, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_err", int'(err_drop), 0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        read_frame(z, z, z, z, -1, 0, -1);

        // count saturation
        for (int k = 0; k < 20; k++) pix(24'h010203, 0, k == 19);
        er = '{15, 0, 0, 0, 0, 0, 0, 0};
        eg = '{30, 0, 0, 0, 0, 0, 0, 0};
        eb = '{45, 0, 0, 0, 0, 0, 0, 0};
        ec = '{15, 0, 0, 0, 0, 0, 0, 0};
        read_frame(er, eg, eb, ec, -1, 0, -1);

        // async reset in the middle of a readout
        pix(24'h112233, 5, 1);
        rd_ready = 1'b1;
        tick();
        repeat (5) tick();
        check("pre_rst_idx", int'(rd_idx), 5);
        check("pre_rst_sum_r", int'(rd_sum_r), 17);
        rst = 1'b1;
        #1;
        check("arst_rd_valid", int'(rd_valid), 0);
        check("arst_rd_idx", int'(rd_idx), 0);
        check("arst_sum_r", int'(rd_sum_r), 0);
        check("arst_count", int'(rd_count), 0);
        check("arst_lv", int'(label_valid), 0);
        check("arst_done", int'(frame_done), 0);
        rd_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        pix(24'h0A0B0C, 6, 1);
        er = '{0, 0, 0, 0, 0, 0, 10, 0};
        eg = '{0, 0, 0, 0, 0, 0, 11, 0};
        eb = '{0, 0, 0, 0, 0, 0, 12, 0};
        ec = '{0, 0, 0, 0, 0, 0, 1, 0};
        read_frame(er, eg, eb, ec, -1, 0, -1);

        // randomized frames with stalls, drops and stray frame_end
        for (int f = 0; f < 6; f++) begin
            int w;
            for (int c = 0; c < 30; c++) begin
                pix_valid = ($urandom_range(0, 3) != 0);
                pix_in = 24'($urandom);
                for (int i = 0; i < 8; i++) d[i] = 10'($urandom_range(0, 15));
                tick();
            end
            frame_end = 1'b1;
            pix_valid = 1'($urandom_range(0, 1));
            tick();
            w = 0;
            while (!frame_done && w < 300) begin
                frame_end = ($urandom_range(0, 4) == 0);
                rd_ready = 1'($urandom_range(0, 1));
                pix_valid = ($urandom_range(0, 7) == 0);
                pix_in = 24'($urandom);
                for (int i = 0; i < 8; i++) d[i] = 10'($urandom_range(0, 15));
                tick();
                w++;
            end
            check("rand_frame_done", int'(frame_done), 1);
            frame_end = 1'b0;
            rd_ready = 1'b0;
            pix_valid = 1'b0;
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cluster_accum.md
# cluster_accum

Downstream stage of the 8-centroid Manhattan-distance unit in the colour-clustering datapath. Each cycle it takes the eight distances plus the pixel they were computed for and selects the nearest centroid (lowest distance, lowest index on ties). It emits that label and adds the pixel into a per-cluster RGB sum and count bank. At frame end it streams the eight bank entries out over a valid/ready port for the centroid-update stage, then zeroes the banks for the next frame.

## Interface
- CNT_W, 16, per-cluster pixel-count width; also bounds pixels per frame
- SUM_W, CNT_W+8, per-channel sum width; sized so sums never overflow while counts are not saturated
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear: zeroes banks, flags and pipeline; returns to ACCUM
- pix_valid  in  1  pixel and distances valid this cycle
- pix_in  in  24  pixel, same-cycle-aligned with d_*; R=[23:16], G=[15:8], B=[7:0]
- d_0..d_7  in  10 each  Manhattan distances to centroids 0..7, unsigned
- frame_end  in  1  single-cycle pulse marking the end of the current frame
- label_valid  out  1  label is valid
- label  out  3  nearest-centroid index
- rd_valid  out  1  bank entry presented
- rd_ready  in  1  consumer accepts the entry
- rd_idx  out  3  cluster index of the presented entry
- rd_sum_r, rd_sum_g, rd_sum_b  out  SUM_W each  channel sums for rd_idx
- rd_count  out  CNT_W  pixel count for rd_idx
- frame_done  out  1  one-cycle pulse after entry 7 is accepted
- err_drop  out  1  sticky: a pixel arrived while not in ACCUM

## Operation
- Stage 1, argmin: strict less-than compare tree, so ties resolve to the lowest index. Registers label, the pixel and label_valid. This stage runs in every state.
- Stage 2, accumulate: on a registered label_valid in ACCUM or DRAIN, adds R, G and B to bank[label] and increments count[label].
- Count saturation: at 2^CNT_W-1, the count and all three sums of that cluster freeze. Other clusters are unaffected.
- FSM ACCUM: pixels are accepted. frame_end moves the FSM to DRAIN. A pixel carried with the frame_end cycle belongs to the closing frame.
- FSM DRAIN: one cycle, lets the stage-1 pixel commit. Then moves to READ with rd_idx=0.
- FSM READ: rd_valid=1. rd_* show bank[rd_idx], stable while rd_ready=0. On rd_valid&&rd_ready, rd_idx increments.
- End of READ: the transfer of idx 7 zeroes all banks, sets rd_idx=0, moves the FSM to ACCUM, and asserts frame_done next cycle.
- Drops: pix_valid in DRAIN or READ discards the pixel and sets err_drop. Its label is still emitted; the banks are untouched.
- frame_end outside ACCUM is ignored.
- clear overrides every other event in the same cycle. It clears err_drop.
- Reset values: label_valid=0, label=0, rd_valid=0, rd_idx=0, rd_sum_*=0, rd_count=0, frame_done=0, err_drop=0. Banks are zero and the FSM is in ACCUM.

## Timing
- label and label_valid: 1 cycle after pix_valid.
- Bank update: visible 2 cycles after pix_valid.
- rd_valid first high 2 cycles after frame_end is sampled.
- Minimum READ time is 8 cycles with rd_ready held high.
- frame_done is high the cycle after the idx-7 handshake. In that cycle the FSM is already in ACCUM and new pixels are accepted.
- rst deasserting mid-frame or mid-READ resumes operation in ACCUM with empty banks. No partial readout is resumed.

## Structure
- Package kmeans_pkg: RGB_W=24, D_W=10, K=8, LBL_W=3, state enum {ACCUM, DRAIN, READ}.
- Sub-module argmin8: purely combinational. Inputs are the eight D_W distances; output is the 3-bit index, lowest index on ties.
- Top level holds the stage registers, the FSM, the banks (8×3 sums + 8 counts) and the read mux.

## Test plan
- Nearest centroid: d = {50,40,30,20,10,60,70,80} -> label=4, label_valid=1 one cycle later.
- Ties: all d=100 -> label=0. d_3=d_5=5, others 9 -> label=3.
- Frame readout: pixels 0x0A141E and 0x143C28 with label 2, then 0xFF0000 with label 7, frame_end on the last pixel. Required readout:
  - idx2: sums r=30, g=80, b=70, count=2.
  - idx7: sums r=255, g=0, b=0, count=1.
  - all other entries zero.
  - frame_done asserted, and the next frame reads all-zero when empty.
- Backpressure: rd_ready=0 for 5 cycles at idx 3 -> rd_idx and rd_* held stable; readout resumes at idx 3.
- Drop: pix_valid during READ -> err_drop=1 and the readout is unchanged. clear -> err_drop=0 and banks zero.
- Async rst asserted mid-READ at idx 5 -> all outputs 0 immediately. After release, a new frame accumulates from empty banks.
